// File: rtl/sm_uart_loader_pkg.sv
// Shared constants for the schoolRISCV UART boot loader.
//   DEF_BIT_CYCLES : default clk cycles per UART bit (50 MHz / 9600 baud)
//   LDR_*          : loader FSM state encodings
//   URX_*          : UART receiver FSM state encodings
package sm_uart_loader_pkg;

  localparam int unsigned DEF_BIT_CYCLES = 5208;

  localparam logic [0:0] LDR_IDLE = 1'b0;
  localparam logic [0:0] LDR_LOAD = 1'b1;

  localparam logic [1:0] URX_IDLE  = 2'd0;
  localparam logic [1:0] URX_START = 2'd1;
  localparam logic [1:0] URX_DATA  = 2'd2;
  localparam logic [1:0] URX_STOP  = 2'd3;

endpackage

// File: rtl/sm_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer and mid-bit sampling.
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_en       : 0 holds the receiver in URX_IDLE (abort)
//   uart_rx     : asynchronous serial line, idles high
//   byte_valid  : one-cycle pulse, byte_data holds the received byte
//   byte_data   : received byte, LSB first on the wire
//   byte_err    : one-cycle pulse on a low stop bit (byte dropped)
module sm_uart_rx
  import sm_uart_loader_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_err_q, byte_err_d;

  // Next-state logic; armed_q blocks a new start until the line has been seen high
  always_comb begin
    sync1_d      = uart_rx;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;

    if (!rx_en) begin
      state_d = URX_IDLE;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        URX_IDLE: begin
          if (!armed_q) begin
            if (sync2_q) armed_d = 1'b1;
          end else if (!sync2_q) begin
            state_d = URX_START;
            cnt_d   = HALF_M1;
          end
        end
        URX_START: begin
          if (cnt_q == '0) begin
            if (!sync2_q) begin
              state_d   = URX_DATA;
              cnt_d     = FULL_M1;
              bit_idx_d = 3'd0;
            end else begin
              state_d = URX_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        URX_DATA: begin
          if (cnt_q == '0) begin
            shift_d = {sync2_q, shift_q[7:1]};
            cnt_d   = FULL_M1;
            if (bit_idx_q == 3'd7) state_d = URX_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        URX_STOP: begin
          if (cnt_q == '0) begin
            state_d = URX_IDLE;
            if (sync2_q) begin
              byte_valid_d = 1'b1;
            end else begin
              byte_err_d = 1'b1;
              armed_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = URX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= URX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      armed_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign byte_err   = byte_err_q;

endmodule

// File: rtl/sm_uart_loader.sv
// UART boot loader: holds the CPU in reset while uart_on is high, assembles
// received bytes little-endian into 32-bit words and writes them to ROM.
//   clk, rst_n : clock, synchronous active-low reset
//   uart_on    : load-mode request (level)
//   uart_rx    : serial line
//   cpu_rst_n  : CPU reset, low while loading
//   rom_we/rom_addr/rom_wdata : one-cycle ROM write port
//   busy       : high in LOAD
//   word_cnt   : words written since LOAD entry, saturating at 2^ADDR_W
//   frame_err  : sticky bad-stop-bit flag, cleared on LOAD entry
module sm_uart_loader
  import sm_uart_loader_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_on,
  input  logic              uart_rx,
  output logic              cpu_rst_n,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              busy,
  output logic [ADDR_W:0]   word_cnt,
  output logic              frame_err
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;

  logic [0:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;

  sm_uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_en      (state_q == LDR_LOAD),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  // Loader FSM, word assembly and ROM write generation
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_addr_d = word_addr_q;
    word_cnt_d  = word_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;

    case (state_q)
      LDR_IDLE: if (uart_on)  state_d = LDR_LOAD;
      LDR_LOAD: if (!uart_on) state_d = LDR_IDLE;
      default:                state_d = LDR_IDLE;
    endcase

    if (state_q == LDR_IDLE && state_d == LDR_LOAD) begin
      byte_idx_d  = 2'd0;
      word_addr_d = '0;
      word_cnt_d  = '0;
      shift_d     = 32'd0;
      frame_err_d = 1'b0;
    end

    // Bytes arriving in the exit cycle are still honoured so a final word completes
    if (state_q == LDR_LOAD) begin
      if (byte_err) frame_err_d = 1'b1;
      if (byte_valid) begin
        case (byte_idx_q)
          2'd0:    shift_d[7:0]   = byte_data;
          2'd1:    shift_d[15:8]  = byte_data;
          2'd2:    shift_d[23:16] = byte_data;
          default: shift_d[31:24] = byte_data;
        endcase
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = word_addr_q;
          rom_wdata_d = {byte_data, shift_q[23:0]};
          word_addr_d = word_addr_q + ADDR_W'(1);
          if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        end
      end
    end
  end

  always_comb begin
    cpu_rst_n_d = (state_d == LDR_IDLE);
    busy_d      = (state_d == LDR_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LDR_IDLE;
      byte_idx_q  <= 2'd0;
      word_addr_q <= '0;
      word_cnt_q  <= '0;
      shift_q     <= 32'd0;
      frame_err_q <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_addr_q <= word_addr_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign busy      = busy_q;
  assign word_cnt  = word_cnt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sm_uart_loader.sv
// Self-checking bench for sm_uart_loader: expected ROM writes are queued as
// bytes are sent and matched against rom_we pulses by a monitor.
module tb_sm_uart_loader;

  localparam int unsigned BC     = 16;
  localparam int unsigned ADDR_W = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              uart_on;
  logic              uart_rx;
  logic              cpu_rst_n;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              busy;
  logic [ADDR_W:0]   word_cnt;
  logic              frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0;
  wr_t exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  sm_uart_loader #(.BIT_CYCLES(BC), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_on   (uart_on),
    .uart_rx   (uart_rx),
    .cpu_rst_n (cpu_rst_n),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .busy      (busy),
    .word_cnt  (word_cnt),
    .frame_err (frame_err)
  );

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (dut.byte_valid) valid_cnt++;
    if (rom_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rom_addr, rom_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rom_addr !== e.addr || rom_wdata !== e.data)
          $display("FAIL rom_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rom_addr, rom_wdata, e.addr, e.data);
        else n_pass++;
      end
      n_checks++;
      if (prev_we) $display("FAIL we_width: rom_we high for more than one cycle");
      else n_pass++;
      last_wr_addr = rom_addr;
    end
    prev_we = rom_we;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BC) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BC) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back('{addr: exp_addr, data: w});
    exp_addr = exp_addr + ADDR_W'(1);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic enter_load();
    uart_on = 1'b1;
    exp_addr = '0;
    @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic exit_load();
    uart_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_on = 1'b0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_rst_n, busy, rom_we, frame_err} !== 4'b0000)
      $display("FAIL reset_ctrl: got cpu_rst_n/busy/we/ferr=%b, required 0000",
               {cpu_rst_n, busy, rom_we, frame_err});
    else n_pass++;
    n_checks++;
    if (rom_addr !== '0 || rom_wdata !== 32'd0 || word_cnt !== '0)
      $display("FAIL reset_data: got addr=%0d data=%h cnt=%0d, required 0/0/0", rom_addr, rom_wdata, word_cnt);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_rst_n !== 1'b1) $display("FAIL reset_release: got cpu_rst_n=%b, required 1", cpu_rst_n);
    else n_pass++;
  endtask

  task automatic test_two_word();
    uart_on = 1'b1;
    exp_addr = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || cpu_rst_n !== 1'b0)
      $display("FAIL load_entry: got busy=%b cpu_rst_n=%b, required 1 0", busy, cpu_rst_n);
    else n_pass++;
    repeat (2) @(negedge clk);
    send_word(32'hA598_1537);
    send_word(32'h8765_4321);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL two_word_pending: got %0d writes missing, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (word_cnt !== 7'd2) $display("FAIL two_word_cnt: got %0d, required 2", word_cnt);
    else n_pass++;
    n_checks++;
    if (cpu_rst_n !== 1'b0) $display("FAIL two_word_hold: got cpu_rst_n=%b, required 0", cpu_rst_n);
    else n_pass++;
    exit_load();
    n_checks++;
    if (busy !== 1'b0 || cpu_rst_n !== 1'b1)
      $display("FAIL load_exit: got busy=%b cpu_rst_n=%b, required 0 1", busy, cpu_rst_n);
    else n_pass++;
  endtask

  task automatic test_partial();
    enter_load();
    for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    exit_load();
    n_checks++;
    if (word_cnt !== 7'd0) $display("FAIL partial_cnt: got %0d, required 0", word_cnt);
    else n_pass++;
    repeat (4) @(negedge clk);
    enter_load();
    send_word(32'hCAFE_F00D);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || word_cnt !== 7'd1)
      $display("FAIL partial_reentry: got pending=%0d cnt=%0d, required 0 1", exp_q.size(), word_cnt);
    else n_pass++;
    exit_load();
  endtask

  task automatic test_frame_err();
    enter_load();
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL ferr_entry: got %b, required 0", frame_err);
    else n_pass++;
    send_byte(8'h55, 1'b0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (frame_err !== 1'b1) $display("FAIL ferr_set: got %b, required 1", frame_err);
    else n_pass++;
    send_word(32'hDDCC_BBAA);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || word_cnt !== 7'd1 || frame_err !== 1'b1)
      $display("FAIL ferr_word: got pending=%0d cnt=%0d ferr=%b, required 0 1 1", exp_q.size(), word_cnt, frame_err);
    else n_pass++;
    exit_load();
    enter_load();
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL ferr_clear: got %b, required 0", frame_err);
    else n_pass++;
    exit_load();
  endtask

  task automatic test_glitch();
    int v0;
    enter_load();
    v0 = valid_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BC) @(negedge clk);
    n_checks++;
    if (valid_cnt != v0) $display("FAIL glitch_valid: got %0d byte_valid pulses, required 0", valid_cnt - v0);
    else n_pass++;
    send_word(32'h1234_5678);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || valid_cnt != v0 + 4)
      $display("FAIL glitch_recover: got pending=%0d valids=%0d, required 0 4", exp_q.size(), valid_cnt - v0);
    else n_pass++;
    exit_load();
  endtask

  task automatic test_wrap();
    enter_load();
    for (int i = 0; i < 64; i++) send_word($urandom);
    repeat (4) @(negedge clk);
    n_checks++;
    if (word_cnt !== 7'd64) $display("FAIL wrap_cnt64: got %0d, required 64", word_cnt);
    else n_pass++;
    send_word($urandom);
    repeat (4) @(negedge clk);
    n_checks++;
    if (word_cnt !== 7'd64 || last_wr_addr !== '0 || exp_q.size() != 0)
      $display("FAIL wrap_65th: got cnt=%0d addr=%0d pending=%0d, required 64 0 0",
               word_cnt, last_wr_addr, exp_q.size());
    else n_pass++;
    exit_load();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    enter_load();
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b1);
    b = 8'h5A;
    uart_rx = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      repeat (BC) @(negedge clk);
    end
    rst_n = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cpu_rst_n, busy, rom_we, frame_err} !== 4'b0000 || rom_addr !== '0 ||
        rom_wdata !== 32'd0 || word_cnt !== '0)
      $display("FAIL mid_reset: got ctrl=%b addr=%0d data=%h cnt=%0d, required all 0",
               {cpu_rst_n, busy, rom_we, frame_err}, rom_addr, rom_wdata, word_cnt);
    else n_pass++;
    rst_n = 1'b1;
    exp_addr = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || cpu_rst_n !== 1'b0)
      $display("FAIL mid_reset_reload: got busy=%b cpu_rst_n=%b, required 1 0", busy, cpu_rst_n);
    else n_pass++;
    repeat (2) @(negedge clk);
    send_word(32'h0BAD_BEEF);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || word_cnt !== 7'd1)
      $display("FAIL mid_reset_word: got pending=%0d cnt=%0d, required 0 1", exp_q.size(), word_cnt);
    else n_pass++;
    exit_load();
  endtask

  initial begin
    rst_n = 1'b0; uart_on = 1'b0; uart_rx = 1'b1;
    test_reset();
    test_two_word();
    test_partial();
    test_frame_err();
    test_glitch();
    test_wrap();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
